dicke_demodulator: RTL and testbench
====================================

// Module: dicke_demodulator
// PURPOSE
//  Sits directly downstream of the XADC capture stage. Consumes interleaved 12-bit samples
//  from A0 (switch reference) and A1 (feedhorn), classifies each switch sample as ON/OFF, and
//  pairs it with the next feed sample. Over one frame of FRAME_PAIRS pairs it accumulates feed
//  samples separately for ON and OFF, then emits Von-Voff sums, per-state counts, and a 1-bit demod.
// PARAMETERS
//  DATA_W       12     ADC sample width (the upper 12 bits of the XADC DRP word)
//  FRAME_PAIRS  1024   switch/feed pairs per output frame; >=2; need not be a power of two
//  THRESH_HI    12'h800 switch sample >= this sets the switch state to ON
//  THRESH_LO    12'h700 switch sample < this sets the switch state to OFF; require THRESH_LO < THRESH_HI
//  ACC_W        DATA_W+$clog2(FRAME_PAIRS+1)  width of each accumulator (derived; never overflows)
// PORTS
//  clk           in   1        system clock (XADC DRP clock domain)
//  clr           in   1        synchronous reset, active-high
//  s_valid       in   1        one-cycle strobe: s_chan/s_data are valid this cycle
//  s_chan        in   1        0 = switch (A0), 1 = feed (A1)
//  s_data        in   DATA_W   unsigned sample
//  result_valid  out  1        one-cycle strobe: result outputs updated this cycle
//  on_sum        out  ACC_W    sum of feed samples paired with switch ON
//  off_sum       out  ACC_W    sum of feed samples paired with switch OFF
//  on_count      out  16       number of ON pairs in the frame
//  off_count     out  16       number of OFF pairs in the frame
//  demod_diff    out  ACC_W+1  signed on_sum - off_sum
//  demod         out  1        1 when demod_diff > 0; held between frames
//  sw_state      out  1        current hysteresis switch state (1 = ON)
//  pair_err      out  1        sticky: a sample arrived out of order; cleared only by clr
//  drop_err      out  1        sticky: s_valid was asserted while in DUMP; cleared only by clr
// BEHAVIOUR
//  Reset (clr=1 at a clk edge): every output is 0, accumulators and counters are 0, and the FSM
//   enters WAIT_SW. clr mid-frame discards the partial frame with no result_valid.
//  Hysteresis: on a switch sample, sw_state <= 1 if s_data >= THRESH_HI, <= 0 if s_data < THRESH_LO;
//   otherwise it holds. It updates on every accepted switch sample in any state except DUMP.
//  FSM states:
//   WAIT_SW:   switch sample -> latch pair_state = new sw_state and go to WAIT_FEED.
//              feed sample -> discard it, set pair_err, and stay.
//   WAIT_FEED: feed sample -> add s_data to on_acc or off_acc per pair_state, increment the
//              matching count and pair_cnt; if pair_cnt reaches FRAME_PAIRS go to DUMP, else WAIT_SW.
//              switch sample -> set pair_err, re-latch pair_state from the new sample, and stay.
//   DUMP:      lasts exactly 1 cycle. Copy the accumulators and counts into the result registers,
//              compute demod_diff and demod, pulse result_valid, zero the accumulators, counts and
//              pair_cnt, then go to WAIT_SW. If s_valid is asserted, drop the sample and set drop_err.
//  Latency: result_valid is asserted 2 clk after the s_valid of the final feed sample
//   (1 cycle for the accept edge, 1 cycle for DUMP). Results hold until the next frame.
//  Arithmetic: unsigned accumulation. demod_diff is computed as the zero-extended difference in
//   ACC_W+1 bits, in two's complement. on_count + off_count == FRAME_PAIRS always.
//  Frames with only one state: the other sum is 0 and its count is 0; no special case.
//  Upstream contract: consecutive s_valid strobes are at least 2 clk apart. A strobe in DUMP is
//   the only case that loses data, and it is flagged by drop_err.
// STRUCTURE
//  Shared package adc_demod_pkg holds:
//   - channel encodings CH_SWITCH=1'b0 and CH_FEED=1'b1
//   - the FSM state encoding (WAIT_SW, WAIT_FEED, DUMP)
//   - the default DATA_W
//   These are shared with the XADC capture stage.
//  Sub-module switch_hysteresis: clk, clr, en, sample[DATA_W], state. It is a registered
//   comparator with parameters THRESH_HI and THRESH_LO.
//  Everything else (FSM, accumulators, result registers) lives in dicke_demodulator.
// TESTING
//  1. FRAME_PAIRS=4; pairs (sw=FFF,feed=100),(000,010),(FFF,100),(000,010) -> on_sum=0x200,
//     off_sum=0x20, on_count=2, off_count=2, demod_diff=0x1E0, demod=1, result_valid high for 1 cycle.
//  2. Hysteresis: switch samples 0x900, 0x780, 0x6FF, 0x780 -> sw_state 1, 1, 0, 0.
//  3. A feed sample first after clr -> pair_err=1 and that feed is not counted; next frame totals
//     are unaffected. Two switch samples in a row -> pair_err=1 and the second sample's state is used.
//  4. s_valid asserted in the DUMP cycle -> drop_err=1 and the next frame's counts exclude it.
//  5. clr asserted mid-frame after 2 pairs -> all outputs 0 next cycle; the next full frame
//     matches scenario 1 exactly.
//  6. FRAME_PAIRS=1024, all ON, feed=0xFFF -> on_sum=0x3FFC00 (fits ACC_W=23), off_count=0,
//     demod_diff=+0x3FFC00.

Source files
------------

// File: rtl/adc_demod_pkg.sv
// Shared definitions for the XADC capture stage and the Dicke demodulator.
//   CH_SWITCH / CH_FEED : channel tags carried with each sample (A0 / A1)
//   demod_state_t       : demodulator FSM encoding
//   DATA_W_DEF          : default ADC sample width
//   hyst_next()         : hysteresis decision shared by the comparator and the FSM
package adc_demod_pkg;

  localparam int   DATA_W_DEF = 12;
  localparam logic CH_SWITCH  = 1'b0;
  localparam logic CH_FEED    = 1'b1;

  typedef enum logic [1:0] {
    WAIT_SW   = 2'd0,
    WAIT_FEED = 2'd1,
    DUMP      = 2'd2
  } demod_state_t;

  // Next switch state given the current state and the two threshold tests.
  // The band between the thresholds holds the previous state.
  function automatic logic hyst_next(input logic cur, input logic ge_hi, input logic lt_lo);
    if (ge_hi)
      return 1'b1;
    else if (lt_lo)
      return 1'b0;
    else
      return cur;
  endfunction

endpackage

// File: rtl/switch_hysteresis.sv
// Registered hysteresis comparator that turns switch-reference samples into
// a clean ON/OFF state.
//   clk    : system clock
//   clr    : synchronous reset, active-high (state -> OFF)
//   en     : sample is an accepted switch sample this cycle
//   sample : unsigned switch-reference sample
//   state  : current switch state (1 = ON)
module switch_hysteresis
  import adc_demod_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] THRESH_HI = DATA_W'(12'h800),
  parameter logic [DATA_W-1:0] THRESH_LO = DATA_W'(12'h700)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] sample,
  output logic              state
);

  always_ff @(posedge clk) begin
    if (clr)
      state <= 1'b0;
    else if (en)
      state <= hyst_next(state, sample >= THRESH_HI, sample < THRESH_LO);
  end

endmodule

// File: rtl/dicke_demodulator.sv
// Dicke-switch demodulator. Takes interleaved switch (A0) and feed (A1)
// samples, pairs each switch sample with the following feed sample, and over
// FRAME_PAIRS pairs accumulates the feed separately for switch ON and OFF.
// At the end of each frame it publishes both sums, the per-state pair counts,
// their signed difference and a 1-bit demodulated decision.
//   clk, clr                 : clock, synchronous active-high reset
//   s_valid, s_chan, s_data  : sample strobe, channel tag (0 switch / 1 feed), sample
//   result_valid             : one-cycle strobe when the result registers update
//   on_sum, off_sum          : feed sums for ON / OFF pairs
//   on_count, off_count      : number of ON / OFF pairs in the frame
//   demod_diff, demod        : signed on_sum - off_sum, and (demod_diff > 0)
//   sw_state                 : current hysteresis switch state
//   pair_err, drop_err       : sticky ordering / dropped-sample flags
module dicke_demodulator
  import adc_demod_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                FRAME_PAIRS = 1024,
  parameter logic [DATA_W-1:0] THRESH_HI   = DATA_W'(12'h800),
  parameter logic [DATA_W-1:0] THRESH_LO   = DATA_W'(12'h700),
  parameter int                ACC_W       = DATA_W + $clog2(FRAME_PAIRS + 1)
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    s_valid,
  input  logic                    s_chan,
  input  logic [DATA_W-1:0]       s_data,
  output logic                    result_valid,
  output logic [ACC_W-1:0]        on_sum,
  output logic [ACC_W-1:0]        off_sum,
  output logic [15:0]             on_count,
  output logic [15:0]             off_count,
  output logic signed [ACC_W:0]   demod_diff,
  output logic                    demod,
  output logic                    sw_state,
  output logic                    pair_err,
  output logic                    drop_err
);

  localparam int CNT_W = $clog2(FRAME_PAIRS + 1);

  demod_state_t          state;
  logic                  pair_state;
  logic [ACC_W-1:0]      on_acc;
  logic [ACC_W-1:0]      off_acc;
  logic [15:0]           on_cnt;
  logic [15:0]           off_cnt;
  logic [CNT_W-1:0]      pair_cnt;
  logic                  sw_take;
  logic                  sw_next;
  logic signed [ACC_W:0] diff;

  // Switch samples are ignored by the comparator during DUMP (they are dropped).
  assign sw_take = s_valid && (s_chan == CH_SWITCH) && (state != DUMP);

  // The comparator register only shows the new state a cycle later, so the
  // pair latch evaluates the same decision combinationally from the live sample.
  assign sw_next = hyst_next(sw_state, s_data >= THRESH_HI, s_data < THRESH_LO);

  // Both sums are zero-extended by one bit so the difference cannot wrap.
  assign diff = $signed({1'b0, on_acc}) - $signed({1'b0, off_acc});

  switch_hysteresis #(
    .DATA_W    (DATA_W),
    .THRESH_HI (THRESH_HI),
    .THRESH_LO (THRESH_LO)
  ) u_hyst (
    .clk    (clk),
    .clr    (clr),
    .en     (sw_take),
    .sample (s_data),
    .state  (sw_state)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= WAIT_SW;
      pair_state   <= 1'b0;
      on_acc       <= '0;
      off_acc      <= '0;
      on_cnt       <= '0;
      off_cnt      <= '0;
      pair_cnt     <= '0;
      result_valid <= 1'b0;
      on_sum       <= '0;
      off_sum      <= '0;
      on_count     <= '0;
      off_count    <= '0;
      demod_diff   <= '0;
      demod        <= 1'b0;
      pair_err     <= 1'b0;
      drop_err     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        WAIT_SW: begin
          if (s_valid) begin
            if (s_chan == CH_SWITCH) begin
              pair_state <= sw_next;
              state      <= WAIT_FEED;
            end else begin
              // Feed with no preceding switch sample: discard it.
              pair_err <= 1'b1;
            end
          end
        end
        WAIT_FEED: begin
          if (s_valid) begin
            if (s_chan == CH_FEED) begin
              if (pair_state) begin
                on_acc <= on_acc + ACC_W'(s_data);
                on_cnt <= on_cnt + 16'd1;
              end else begin
                off_acc <= off_acc + ACC_W'(s_data);
                off_cnt <= off_cnt + 16'd1;
              end
              pair_cnt <= pair_cnt + CNT_W'(1);
              state    <= (pair_cnt == CNT_W'(FRAME_PAIRS - 1)) ? DUMP : WAIT_SW;
            end else begin
              // Back-to-back switch samples: the newest one defines the pair.
              pair_err   <= 1'b1;
              pair_state <= sw_next;
            end
          end
        end
        DUMP: begin
          on_sum       <= on_acc;
          off_sum      <= off_acc;
          on_count     <= on_cnt;
          off_count    <= off_cnt;
          demod_diff   <= diff;
          demod        <= !diff[ACC_W] && (diff != '0);
          result_valid <= 1'b1;
          on_acc       <= '0;
          off_acc      <= '0;
          on_cnt       <= '0;
          off_cnt      <= '0;
          pair_cnt     <= '0;
          state        <= WAIT_SW;
          if (s_valid)
            drop_err <= 1'b1;
        end
        default: state <= WAIT_SW;
      endcase
    end
  end

endmodule

// File: tb/tb_dicke_demodulator.sv
// Bench for dicke_demodulator: a 4-pair instance checked every cycle against
// a frame-level reference model plus directed expectations, and a 1024-pair
// instance checked for the full-scale accumulation case.
module tb_dicke_demodulator;
  import adc_demod_pkg::*;

  localparam int DW   = 12;
  localparam int FP_S = 4;
  localparam int FP_L = 1024;
  localparam int AW_S = DW + $clog2(FP_S + 1);
  localparam int AW_L = DW + $clog2(FP_L + 1);

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_chan = 1'b0;
  logic [DW-1:0] s_data = '0;

  logic            rv_s, demod_s, sw_s, perr_s, derr_s;
  logic [AW_S-1:0] on_sum_s, off_sum_s;
  logic [15:0]     on_cnt_s, off_cnt_s;
  logic [AW_S:0]   diff_s;

  logic            rv_l, demod_l, sw_l, perr_l, derr_l;
  logic [AW_L-1:0] on_sum_l, off_sum_l;
  logic [15:0]     on_cnt_l, off_cnt_l;
  logic [AW_L:0]   diff_l;

  always #5 clk = ~clk;

  dicke_demodulator #(.DATA_W(DW), .FRAME_PAIRS(FP_S)) dut_s (
    .clk(clk), .clr(clr), .s_valid(s_valid), .s_chan(s_chan), .s_data(s_data),
    .result_valid(rv_s), .on_sum(on_sum_s), .off_sum(off_sum_s),
    .on_count(on_cnt_s), .off_count(off_cnt_s), .demod_diff(diff_s),
    .demod(demod_s), .sw_state(sw_s), .pair_err(perr_s), .drop_err(derr_s)
  );

  dicke_demodulator #(.DATA_W(DW), .FRAME_PAIRS(FP_L)) dut_l (
    .clk(clk), .clr(clr), .s_valid(s_valid), .s_chan(s_chan), .s_data(s_data),
    .result_valid(rv_l), .on_sum(on_sum_l), .off_sum(off_sum_l),
    .on_count(on_cnt_l), .off_count(off_cnt_l), .demod_diff(diff_l),
    .demod(demod_l), .sw_state(sw_l), .pair_err(perr_l), .drop_err(derr_l)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model for the 4-pair instance ----------------
  // Tracks which pairs have formed in the current frame; when the frame is
  // complete the results become visible one cycle later.
  bit     m_sw, m_pstate, m_expect_feed, m_perr, m_derr, m_rv, m_frame_done;
  longint m_on, m_off, m_onc, m_offc, m_pairs;
  longint r_on, r_off, r_onc, r_offc;
  bit     r_demod;
  logic [AW_S:0] r_diff;

  function automatic bit hyst(input bit cur, input int d);
    if (d >= 'h800) return 1'b1;
    if (d < 'h700)  return 1'b0;
    return cur;
  endfunction

  task automatic model_step();
    m_rv = 1'b0;
    if (clr) begin
      m_sw = 0; m_pstate = 0; m_expect_feed = 0; m_perr = 0; m_derr = 0; m_frame_done = 0;
      m_on = 0; m_off = 0; m_onc = 0; m_offc = 0; m_pairs = 0;
      r_on = 0; r_off = 0; r_onc = 0; r_offc = 0; r_demod = 0; r_diff = '0;
    end else if (m_frame_done) begin
      m_frame_done = 0;
      r_on = m_on; r_off = m_off; r_onc = m_onc; r_offc = m_offc;
      r_diff  = (AW_S + 1)'(m_on - m_off);
      r_demod = (m_on > m_off);
      m_rv = 1'b1;
      m_on = 0; m_off = 0; m_onc = 0; m_offc = 0; m_pairs = 0;
      if (s_valid) m_derr = 1'b1;
    end else if (s_valid) begin
      if (s_chan == CH_SWITCH) begin
        m_sw = hyst(m_sw, int'(s_data));
        if (m_expect_feed) m_perr = 1'b1;
        m_pstate = m_sw;
        m_expect_feed = 1'b1;
      end else if (!m_expect_feed) begin
        m_perr = 1'b1;
      end else begin
        if (m_pstate) begin m_on += longint'(s_data); m_onc++; end
        else          begin m_off += longint'(s_data); m_offc++; end
        m_expect_feed = 1'b0;
        m_pairs++;
        if (m_pairs == FP_S) m_frame_done = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("m_result_valid", 64'(rv_s),      64'(m_rv));
      chk("m_on_sum",       64'(on_sum_s),  64'(r_on));
      chk("m_off_sum",      64'(off_sum_s), 64'(r_off));
      chk("m_on_count",     64'(on_cnt_s),  64'(r_onc));
      chk("m_off_count",    64'(off_cnt_s), 64'(r_offc));
      chk("m_demod_diff",   64'(diff_s),    64'(r_diff));
      chk("m_demod",        64'(demod_s),   64'(r_demod));
      chk("m_sw_state",     64'(sw_s),      64'(m_sw));
      chk("m_pair_err",     64'(perr_s),    64'(m_perr));
      chk("m_drop_err",     64'(derr_s),    64'(m_derr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic ch, input logic [DW-1:0] d);
    @(negedge clk);
    s_valid = 1'b1; s_chan = ch; s_data = d;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic frame_ref();
    send(CH_SWITCH, 12'hFFF); send(CH_FEED, 12'h100);
    send(CH_SWITCH, 12'h000); send(CH_FEED, 12'h010);
    send(CH_SWITCH, 12'hFFF); send(CH_FEED, 12'h100);
    send(CH_SWITCH, 12'h000); send(CH_FEED, 12'h010);
  endtask

  task automatic wait_rv_s(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (rv_s) seen = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_rv_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic chk_ref_result(input string tag);
    wait_rv_s(tag);
    chk({tag, "_on_sum"},    64'(on_sum_s),  64'h200);
    chk({tag, "_off_sum"},   64'(off_sum_s), 64'h20);
    chk({tag, "_on_count"},  64'(on_cnt_s),  64'd2);
    chk({tag, "_off_count"}, 64'(off_cnt_s), 64'd2);
    chk({tag, "_diff"},      64'(diff_s),    64'h1E0);
    chk({tag, "_demod"},     64'(demod_s),   64'd1);
    @(negedge clk);
    chk({tag, "_rv_one_cycle"}, 64'(rv_s), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rv"},      64'(rv_s),      64'd0);
    chk({tag, "_on_sum"},  64'(on_sum_s),  64'd0);
    chk({tag, "_off_sum"}, 64'(off_sum_s), 64'd0);
    chk({tag, "_cnts"},    64'({on_cnt_s, off_cnt_s}), 64'd0);
    chk({tag, "_diff"},    64'(diff_s),    64'd0);
    chk({tag, "_flags"},   64'({demod_s, sw_s, perr_s, derr_s}), 64'd0);
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk_all_zero("reset");
    clr = 1'b0;

    // Reference 4-pair frame
    frame_ref();
    chk_ref_result("frame1");

    // Hysteresis walk
    send(CH_SWITCH, 12'h900); chk("hyst_900", 64'(sw_s), 64'd1);
    send(CH_SWITCH, 12'h780); chk("hyst_780a", 64'(sw_s), 64'd1);
    send(CH_SWITCH, 12'h6FF); chk("hyst_6ff", 64'(sw_s), 64'd0);
    send(CH_SWITCH, 12'h780); chk("hyst_780b", 64'(sw_s), 64'd0);
    chk("hyst_pair_err", 64'(perr_s), 64'd1);

    // Feed first after clr, then a clean frame
    do_clr();
    chk_all_zero("clr1");
    send(CH_FEED, 12'h123);
    chk("feed_first_pair_err", 64'(perr_s), 64'd1);
    frame_ref();
    chk_ref_result("after_orphan");

    // Two switch samples in a row: the second (ON) defines the pair
    send(CH_SWITCH, 12'h000); send(CH_SWITCH, 12'hFFF); send(CH_FEED, 12'h100);
    send(CH_SWITCH, 12'hFFF); send(CH_FEED, 12'h100);
    send(CH_SWITCH, 12'h000); send(CH_FEED, 12'h010);
    send(CH_SWITCH, 12'h000); send(CH_FEED, 12'h010);
    chk_ref_result("double_sw");

    // Strobe during DUMP is dropped
    send(CH_SWITCH, 12'hFFF); send(CH_FEED, 12'h100);
    send(CH_SWITCH, 12'h000); send(CH_FEED, 12'h010);
    send(CH_SWITCH, 12'hFFF); send(CH_FEED, 12'h100);
    send(CH_SWITCH, 12'h000);
    @(negedge clk);
    s_valid = 1'b1; s_chan = CH_FEED; s_data = 12'h010;
    @(negedge clk);
    s_data = 12'h555;
    @(negedge clk);
    s_valid = 1'b0;
    chk("drop_err", 64'(derr_s), 64'd1);
    frame_ref();
    chk_ref_result("after_drop");

    // clr mid-frame
    do_clr();
    send(CH_SWITCH, 12'hFFF); send(CH_FEED, 12'h100);
    send(CH_SWITCH, 12'h000); send(CH_FEED, 12'h010);
    do_clr();
    chk_all_zero("clr_mid");
    frame_ref();
    chk_ref_result("after_clr_mid");

    // Randomized traffic, mostly well-formed pairs
    for (int i = 0; i < 300; i++) begin
      int kind = $urandom_range(0, 19);
      logic [DW-1:0] sv, fv;
      sv = ($urandom_range(0, 1) == 0) ? DW'($urandom) : DW'($urandom_range(12'h6F0, 12'h810));
      fv = DW'($urandom);
      if (kind == 0)      send(CH_FEED, fv);
      else if (kind == 1) send(CH_SWITCH, sv);
      else begin
        send(CH_SWITCH, sv);
        repeat ($urandom_range(0, 1)) @(negedge clk);
        send(CH_FEED, fv);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Full-scale 1024-pair frame on the large instance
    do_clr();
    for (int i = 0; i < FP_L; i++) begin
      send(CH_SWITCH, 12'hFFF);
      send(CH_FEED, 12'hFFF);
    end
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        if (rv_l) seen = 1'b1;
        else @(negedge clk);
      end
      chk("big_rv_seen", 64'(seen), 64'd1);
    end
    chk("big_on_sum",    64'(on_sum_l),  64'h3FFC00);
    chk("big_off_sum",   64'(off_sum_l), 64'd0);
    chk("big_on_count",  64'(on_cnt_l),  64'd1024);
    chk("big_off_count", 64'(off_cnt_l), 64'd0);
    chk("big_diff",      64'(diff_l),    64'h3FFC00);
    chk("big_demod",     64'(demod_l),   64'd1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
